// File: rtl/dmem_stall.sv
// dmem_stall: word-organised data memory with a valid/ready request channel
// and a fixed, configurable number of wait states between accept and access.
//
// Ports:
//   clk            rising-edge clock for all state
//   reset          asynchronous, active-low reset
//   req_valid      request present
//   req_ready      block can accept a request this cycle (decoded from state)
//   req_write      1 = store, 0 = load
//   req_address    byte address; word index is address[ADDR_WIDTH+1:2]
//   req_write_data store data
//   req_byte_en    per-byte store enable (ignored for loads)
//   resp_valid     one-cycle pulse when the access completes
//   resp_read_data load data (0 for stores), held until the next response
//   resp_error     misaligned access rejected, valid with resp_valid
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned stores (and loads when DATA_WIDTH == 32) respond
//                with resp_error = 1, read data 0, and leave memory untouched
//   undefined -> address[1:0] is ignored and resp_error is always 0
module dmem_stall #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_address,
  input  logic [DATA_WIDTH-1:0]   req_write_data,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_read_data,
  output logic                    resp_error
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  // Counter preload; guarded so LATENCY == 0 does not produce a negative value.
  localparam int          CNT_INIT_I = (LATENCY > 0) ? (LATENCY - 1) : 0;
  localparam logic [3:0]  CNT_INIT   = 4'(CNT_INIT_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic                    wr_r;
  logic [ADDR_WIDTH+1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [BE_WIDTH-1:0]     be_r;
  logic [DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];

  logic                    accept_s;
  logic                    do_access_s;
  logic                    acc_write_s;
  logic [ADDR_WIDTH+1:0]   acc_addr_s;
  logic [DATA_WIDTH-1:0]   acc_wdata_s;
  logic [BE_WIDTH-1:0]     acc_be_s;
  logic [ADDR_WIDTH-1:0]   idx_s;
  logic [DATA_WIDTH-1:0]   rdata_s;
  logic [DATA_WIDTH-1:0]   merged_s;
  logic                    misalign_s;
  logic                    mem_we_s;
  logic                    unused_s;

  // Replace the enabled bytes of a stored word with the new store data.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  // Stores must be word aligned; loads only when the word is 32 bits wide.
  function automatic logic is_misaligned(input logic write, input logic [1:0] lo);
    return (lo != 2'b00) && (write || (DATA_WIDTH == 32));
  endfunction

  assign misalign_s = is_misaligned(acc_write_s, acc_addr_s[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // Ready decodes the state and is held low while reset is asserted.
  assign req_ready = reset && (state_r != ST_BUSY);
  assign accept_s  = req_valid && req_ready;

  // Zero wait states access on the accept edge itself, so the live request
  // feeds the array; otherwise the latched copy does.
  always_comb begin
    if (LATENCY == 0) begin
      acc_write_s = req_write;
      acc_addr_s  = req_address[ADDR_WIDTH+1:0];
      acc_wdata_s = req_write_data;
      acc_be_s    = req_byte_en;
      do_access_s = accept_s;
    end else begin
      acc_write_s = wr_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_be_s    = be_r;
      do_access_s = (state_r == ST_BUSY) && (cnt_r == 4'd0);
    end
  end

  assign idx_s    = acc_addr_s[ADDR_WIDTH+1:2];
  assign rdata_s  = mem_r[idx_s];
  assign merged_s = merge_bytes(rdata_s, acc_wdata_s, acc_be_s);
  assign mem_we_s = do_access_s && acc_write_s && !misalign_s;
  // Upper address bits alias by design and may be otherwise unread.
  assign unused_s = ^{req_address, acc_addr_s};

  // Storage array: not reset, written only when an access completes.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  // Request FSM, wait-state counter, request latch and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      wr_r           <= 1'b0;
      addr_r         <= '0;
      wdata_r        <= '0;
      be_r           <= '0;
      resp_valid     <= 1'b0;
      resp_read_data <= '0;
      resp_error     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_r)
        ST_IDLE, ST_RESP: begin
          if (accept_s) begin
            wr_r    <= req_write;
            addr_r  <= req_address[ADDR_WIDTH+1:0];
            wdata_r <= req_write_data;
            be_r    <= req_byte_en;
            if (LATENCY == 0) begin
              state_r <= ST_RESP;
            end else begin
              cnt_r   <= CNT_INIT;
              state_r <= ST_BUSY;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (do_access_s) begin
        resp_valid <= 1'b1;
        resp_error <= misalign_s;
        if (acc_write_s || misalign_s) begin
          resp_read_data <= '0;
        end else begin
          resp_read_data <= rdata_s;
        end
      end
    end
  end

endmodule
